adpll_tx_bit_serializer: RTL and testbench
==========================================

Name: adpll_tx_bit_serializer

Overview:
- Upstream feeder for the ADPLL controller's TX modulation input.
- Accepts payload bytes through a valid/ready write port and buffers them in a small FIFO.
- Once the ADPLL is in TX mode and reports channel_lock, serializes the bytes LSB-first onto data_mod, one bit per programmable number of reference-clock cycles.
- Reports underrun and modulation activity to the host.

Parameters:
FIFO_DEPTH, 8, byte FIFO depth; power of two, at least 2
LVLW, 4, fifo_level width; equals log2(FIFO_DEPTH)+1

Ports:
clk  in  1  ADPLL reference clock; block logic on posedge
rst_n  in  1  asynchronous active-low reset
en  in  1  global enable; when 0, all state frozen
adpll_mode  in  2  PD=0, TEST=1, RX=2, TX=3
channel_lock  in  1  lock flag from ADPLL controller
sym_period  in  8  reference cycles per symbol; values 0 and 1 treated as 2
wr_valid  in  1  byte write request
wr_data  in  8  payload byte
wr_ready  out  1  FIFO not full
clr_underrun  in  1  synchronous clear of the underrun flag
data_mod  out  1  modulation bit to ADPLL controller
mod_active  out  1  high while a valid bit is on data_mod
underrun  out  1  sticky flag: FIFO empty at a byte boundary during RUN
fifo_level  out  LVLW  bytes currently buffered

Behaviour:
- Reset (rst_n=0, asynchronous):
  - FIFO empty; fifo_level=0; wr_ready=1.
  - data_mod=0, mod_active=0, underrun=0; state=IDLE.
  - Shifter, bit counter and cycle counter all cleared.
- en=0: no state, FIFO or counter changes; writes ignored; wr_ready still reflects "not full"; outputs hold.
- go = (adpll_mode==TX) & channel_lock.
- FIFO:
  - Write occurs when wr_valid & wr_ready & en.
  - wr_ready = (fifo_level != FIFO_DEPTH); no bypass.
  - A byte written on edge k is poppable from edge k+1.
  - Simultaneous write and pop: level unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- FIFO flush:
  - FIFO is flushed (level=0) on the edge where adpll_mode is sampled != TX.
  - FIFO is retained when only channel_lock drops.
- Effective period P = max(sym_period,2). P is latched at each byte load; changes mid-byte take effect at the next byte.
- State IDLE:
  - data_mod=0, mod_active=0.
  - If go and fifo_level>0, then on that same edge: pop the byte into the shifter, data_mod<=byte[0], mod_active<=1, cyc=0, bit=0, go to RUN.
- State RUN:
  - cyc increments each cycle. When cyc==P-1: cyc<=0, bit<=bit+1, data_mod<=next shifter bit.
  - Each bit is held exactly P cycles.
  - Byte boundary (bit==7 and cyc==P-1):
    - If FIFO non-empty: pop, data_mod<=newbyte[0], bit<=0. Seamless, no gap cycle.
    - Else: go to STARVE, data_mod<=0, mod_active<=0, underrun<=1.
- State STARVE:
  - When fifo_level>0 and go: load as in IDLE, go to RUN.
  - When go drops: go to IDLE.
- Abort:
  - go=0 in RUN (any cycle) → next edge to IDLE.
  - Partial byte discarded; data_mod<=0, mod_active<=0.
  - underrun not set by an abort.
- underrun clearing:
  - underrun clears only on clr_underrun=1 (with en=1).
  - If set and clear occur on the same edge, set wins.
- Latency: byte present and go high at edge k → data_mod valid from edge k; total byte airtime 8·P cycles.

Test Plan:
- Reset check:
  - Stimulus: assert rst_n=0 mid-stream.
  - Required response: data_mod=0, mod_active=0, underrun=0, fifo_level=0, wr_ready=1 immediately; after release, state is IDLE.
- Single byte:
  - Stimulus: sym_period=4, adpll_mode=TX, channel_lock=1, write 0xA5.
  - Required response: data_mod sequence 1,0,1,0,0,1,0,1, each bit exactly 4 cycles; mod_active high 32 cycles; then underrun=1, state STARVE.
- Back-to-back bytes:
  - Stimulus: sym_period=0, write 0x0F then 0xF0 before lock.
  - Required response: after lock, 16 bits 1111000000001111 at 2 cycles each, no gap; underrun set only after bit 15.
- FIFO full:
  - Stimulus: write 9 bytes with go=0.
  - Required response: fifo_level=8, wr_ready=0, 9th byte dropped; then switch adpll_mode to RX, after which fifo_level=0.
- Lock drop mid-byte:
  - Stimulus: drop channel_lock at bit 3 of 0xFF.
  - Required response: next edge mod_active=0, data_mod=0, underrun=0; remaining FIFO bytes retained; on relock, transmission restarts with the next byte at bit 0.
- Enable freeze and underrun clear:
  - Stimulus: hold en=0 for 10 cycles in RUN; then pulse clr_underrun coincident with a new underrun event.
  - Required response: during en=0 the bit timing pauses and resumes exactly where it stopped; after the coincident clear, underrun stays 1 and clears on a later isolated clr_underrun pulse.

Source files
------------

// File: rtl/adpll_tx_bit_serializer.sv
`timescale 1ns/1ps
// adpll_tx_bit_serializer
// Buffers payload bytes in a small FIFO and, while the ADPLL is in TX mode
// and locked, shifts them out LSB-first on data_mod, holding each bit for a
// programmable number of reference cycles. Flags starvation at byte
// boundaries as a sticky underrun.
module adpll_tx_bit_serializer #(
  parameter int FIFO_DEPTH = 8,
  parameter int LVLW       = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  input  logic [1:0]      adpll_mode,
  input  logic            channel_lock,
  input  logic [7:0]      sym_period,
  input  logic            wr_valid,
  input  logic [7:0]      wr_data,
  output logic            wr_ready,
  input  logic            clr_underrun,
  output logic            data_mod,
  output logic            mod_active,
  output logic            underrun,
  output logic [LVLW-1:0] fifo_level
);

  localparam int PTRW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [1:0] MODE_TX = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_STARVE
  } state_t;

  state_t          state_q, state_d;
  logic [7:0]      mem_q [FIFO_DEPTH];
  logic [7:0]      mem_d [FIFO_DEPTH];
  logic [PTRW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTRW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVLW-1:0] level_q, level_d;
  logic [7:0]      shift_q, shift_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      cyc_q, cyc_d;
  logic [7:0]      period_q, period_d;
  logic            data_mod_q, data_mod_d;
  logic            mod_active_q, mod_active_d;
  logic            underrun_q, underrun_d;

  logic            go;
  logic            fifo_full;
  logic            fifo_empty;
  logic            push;
  logic            pop;
  logic            set_underrun;
  logic [7:0]      eff_period;
  logic [7:0]      period_last;
  logic [7:0]      head;

  assign go          = (adpll_mode == MODE_TX) & channel_lock;
  assign fifo_full   = (level_q == LVLW'(FIFO_DEPTH));
  assign fifo_empty  = (level_q == '0);
  assign push        = en & wr_valid & ~fifo_full;
  assign eff_period  = (sym_period < 8'd2) ? 8'd2 : sym_period;
  assign period_last = period_q - 8'd1;
  assign head        = mem_q[rd_ptr_q];

  assign wr_ready   = ~fifo_full;
  assign fifo_level = level_q;
  assign data_mod   = data_mod_q;
  assign mod_active = mod_active_q;
  assign underrun   = underrun_q;

  // Serializer FSM: byte loads, per-bit timing, byte boundaries and aborts
  always_comb begin
    state_d      = state_q;
    shift_d      = shift_q;
    bit_d        = bit_q;
    cyc_d        = cyc_q;
    period_d     = period_q;
    data_mod_d   = data_mod_q;
    mod_active_d = mod_active_q;
    pop          = 1'b0;
    set_underrun = 1'b0;

    if (en) begin
      case (state_q)
        ST_IDLE, ST_STARVE: begin
          if (go && !fifo_empty) begin
            pop = 1'b1;
          end else if (!go) begin
            state_d = ST_IDLE;
          end
        end
        ST_RUN: begin
          if (!go) begin
            state_d      = ST_IDLE;
            data_mod_d   = 1'b0;
            mod_active_d = 1'b0;
          end else if (cyc_q == period_last) begin
            cyc_d = 8'd0;
            if (bit_q == 3'd7) begin
              if (!fifo_empty) begin
                pop = 1'b1;
              end else begin
                state_d      = ST_STARVE;
                data_mod_d   = 1'b0;
                mod_active_d = 1'b0;
                set_underrun = 1'b1;
              end
            end else begin
              bit_d      = bit_q + 3'd1;
              shift_d    = {1'b0, shift_q[7:1]};
              data_mod_d = shift_q[1];
            end
          end else begin
            cyc_d = cyc_q + 8'd1;
          end
        end
        default: begin
          state_d      = ST_IDLE;
          data_mod_d   = 1'b0;
          mod_active_d = 1'b0;
        end
      endcase

      if (pop) begin
        state_d      = ST_RUN;
        shift_d      = head;
        data_mod_d   = head[0];
        mod_active_d = 1'b1;
        cyc_d        = 8'd0;
        bit_d        = 3'd0;
        period_d     = eff_period;
      end
    end
  end

  // Sticky underrun: a new starvation event outranks a simultaneous clear
  always_comb begin
    underrun_d = underrun_q;
    if (set_underrun) begin
      underrun_d = 1'b1;
    end else if (en && clr_underrun) begin
      underrun_d = 1'b0;
    end
  end

  // Byte FIFO: write/pop bookkeeping, flushed whenever the ADPLL leaves TX
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;

    if (en) begin
      if (adpll_mode != MODE_TX) begin
        wr_ptr_d = '0;
        rd_ptr_d = '0;
        level_d  = '0;
      end else begin
        if (push) begin
          mem_d[wr_ptr_q] = wr_data;
          wr_ptr_d        = wr_ptr_q + PTRW'(1);
        end
        if (pop) begin
          rd_ptr_d = rd_ptr_q + PTRW'(1);
        end
        case ({push, pop})
          2'b10:   level_d = level_q + LVLW'(1);
          2'b01:   level_d = level_q - LVLW'(1);
          default: level_d = level_q;
        endcase
      end
    end
  end

  // State, counter and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      shift_q      <= 8'd0;
      bit_q        <= 3'd0;
      cyc_q        <= 8'd0;
      period_q     <= 8'd2;
      data_mod_q   <= 1'b0;
      mod_active_q <= 1'b0;
      underrun_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      shift_q      <= shift_d;
      bit_q        <= bit_d;
      cyc_q        <= cyc_d;
      period_q     <= period_d;
      data_mod_q   <= data_mod_d;
      mod_active_q <= mod_active_d;
      underrun_q   <= underrun_d;
    end
  end

  // FIFO storage and pointer registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= 8'd0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

endmodule

// File: tb/tb_adpll_tx_bit_serializer.sv
`timescale 1ns/1ps
// Self-checking bench for adpll_tx_bit_serializer: directed scenarios plus
// randomized traffic, all compared against a byte-queue/airtime model.
module tb_adpll_tx_bit_serializer;

  localparam int DEPTH = 8;

  logic       clk;
  logic       rstN;
  logic       en;
  logic [1:0] adpllMode;
  logic       channelLock;
  logic [7:0] symPeriod;
  logic       wrValid;
  logic [7:0] wrData;
  logic       wrReady;
  logic       clrUnderrun;
  logic       dataMod;
  logic       modActive;
  logic       underrun;
  logic [3:0] fifoLevel;

  int nChecks = 0;
  int nFails  = 0;

  // Reference model: queued bytes, the byte on air and elapsed airtime
  bit [7:0] mQ[$];
  bit       mActive;
  bit [7:0] mCur;
  int       mP;
  int       mT;
  bit       mUnder;

  adpll_tx_bit_serializer #(.FIFO_DEPTH(DEPTH), .LVLW(4)) dut (
    .clk          (clk),
    .rst_n        (rstN),
    .en           (en),
    .adpll_mode   (adpllMode),
    .channel_lock (channelLock),
    .sym_period   (symPeriod),
    .wr_valid     (wrValid),
    .wr_data      (wrData),
    .wr_ready     (wrReady),
    .clr_underrun (clrUnderrun),
    .data_mod     (dataMod),
    .mod_active   (modActive),
    .underrun     (underrun),
    .fifo_level   (fifoLevel)
  );

  // Reference clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nChecks++;
    if (got !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int effPeriod();
    return (symPeriod < 8'd2) ? 2 : int'(symPeriod);
  endfunction

  function automatic bit modelData();
    return mActive ? mCur[mT / mP] : 1'b0;
  endfunction

  function automatic bit goNow();
    return (adpllMode == 2'd3) && channelLock;
  endfunction

  task automatic modelReset();
    mQ.delete();
    mActive = 0;
    mCur    = 0;
    mP      = 2;
    mT      = 0;
    mUnder  = 0;
  endtask

  task automatic loadByte();
    mCur    = mQ.pop_front();
    mP      = effPeriod();
    mT      = 0;
    mActive = 1;
  endtask

  // One enabled reference edge: bytes leave the queue at airtime ends
  task automatic modelStep();
    int sz;
    bit setU;
    sz   = mQ.size();
    setU = 0;
    if (!mActive) begin
      if (goNow() && sz > 0) loadByte();
    end else if (!goNow()) begin
      mActive = 0;
    end else if (mT == 8 * mP - 1) begin
      if (sz > 0) loadByte();
      else begin
        mActive = 0;
        setU    = 1;
      end
    end else begin
      mT++;
    end
    if (adpllMode != 2'd3) mQ.delete();
    else if (wrValid && sz < DEPTH) mQ.push_back(wrData);
    if (setU) mUnder = 1;
    else if (clrUnderrun) mUnder = 0;
  endtask

  task automatic checkAll();
    checkOutput("data_mod", dataMod, modelData());
    checkOutput("mod_active", modActive, mActive);
    checkOutput("underrun", underrun, mUnder);
    checkOutput("fifo_level", fifoLevel, mQ.size());
    checkOutput("wr_ready", wrReady, mQ.size() != DEPTH);
  endtask

  task automatic applyStimulus();
    @(posedge clk);
    if (en) modelStep();
    #1;
    checkAll();
  endtask

  // Asynchronous reset pulse placed between clock edges
  task automatic doReset();
    rstN = 1'b0;
    #1;
    modelReset();
    checkAll();
    checkOutput("rst_level", fifoLevel, 0);
    checkOutput("rst_ready", wrReady, 1);
    #1;
    rstN = 1'b1;
  endtask

  task automatic writeByte(input logic [7:0] b);
    wrValid = 1'b1;
    wrData  = b;
    applyStimulus();
    wrValid = 1'b0;
  endtask

  logic [63:0] seq;
  logic [63:0] expSeq;
  int          nAct;
  bit          urunWhileActive;
  bit          found;

  initial begin
    rstN = 1'b0; en = 1'b0; adpllMode = 2'd0; channelLock = 1'b0;
    symPeriod = 8'd0; wrValid = 1'b0; wrData = 8'd0; clrUnderrun = 1'b0;
    modelReset();
    #3;
    checkAll();
    #9;
    rstN = 1'b1;

    // Single byte 0xA5 at four cycles per bit
    en = 1'b1; adpllMode = 2'd3; channelLock = 1'b1; symPeriod = 8'd4;
    writeByte(8'hA5);
    seq = '0; nAct = 0;
    for (int i = 0; i < 40; i++) begin
      applyStimulus();
      if (modActive && nAct < 64) begin
        seq[nAct] = dataMod;
        nAct++;
      end
    end
    expSeq = '0;
    for (int i = 0; i < 32; i++) expSeq[i] = 1'((8'hA5 >> (i / 4)) & 8'h01);
    checkOutput("a5_active_cycles", nAct, 32);
    checkOutput("a5_sequence", seq, expSeq);
    checkOutput("a5_underrun", underrun, 1);
    clrUnderrun = 1'b1; applyStimulus(); clrUnderrun = 1'b0;
    checkOutput("a5_cleared", underrun, 0);

    // Back-to-back 0x0F, 0xF0 queued before lock, minimum period
    channelLock = 1'b0; symPeriod = 8'd0;
    writeByte(8'h0F);
    writeByte(8'hF0);
    channelLock = 1'b1;
    seq = '0; nAct = 0; urunWhileActive = 0;
    for (int i = 0; i < 40; i++) begin
      applyStimulus();
      if (modActive && nAct < 64) begin
        seq[nAct] = dataMod;
        nAct++;
        if (underrun) urunWhileActive = 1;
      end
    end
    expSeq = '0;
    for (int i = 0; i < 32; i++) expSeq[i] = 1'((16'hF00F >> (i / 2)) & 16'h0001);
    checkOutput("b2b_active_cycles", nAct, 32);
    checkOutput("b2b_sequence", seq, expSeq);
    checkOutput("b2b_no_early_urun", urunWhileActive, 0);
    checkOutput("b2b_underrun", underrun, 1);

    // FIFO full with go low, then flush by leaving TX
    channelLock = 1'b0;
    clrUnderrun = 1'b1; applyStimulus(); clrUnderrun = 1'b0;
    for (int i = 0; i < 9; i++) writeByte(8'($urandom));
    checkOutput("full_level", fifoLevel, 8);
    checkOutput("full_ready", wrReady, 0);
    adpllMode = 2'd2; applyStimulus(); adpllMode = 2'd3;
    checkOutput("flush_level", fifoLevel, 0);

    // Lock drop at bit 3 of 0xFF, relock resumes with the next byte
    symPeriod = 8'd2;
    writeByte(8'hFF);
    writeByte(8'h55);
    channelLock = 1'b1;
    for (int i = 0; i < 7; i++) applyStimulus();
    channelLock = 1'b0; applyStimulus();
    checkOutput("drop_active", modActive, 0);
    checkOutput("drop_data", dataMod, 0);
    checkOutput("drop_underrun", underrun, 0);
    checkOutput("drop_retained", fifoLevel, 1);
    channelLock = 1'b1; applyStimulus();
    checkOutput("relock_active", modActive, 1);
    checkOutput("relock_bit0", dataMod, 1);
    for (int i = 0; i < 5; i++) applyStimulus();
    doReset();
    for (int i = 0; i < 3; i++) applyStimulus();

    // Enable freeze mid-byte, then clear coincident with a new underrun
    symPeriod = 8'd3;
    writeByte(8'h3C);
    for (int i = 0; i < 5; i++) applyStimulus();
    en = 1'b0;
    for (int i = 0; i < 10; i++) applyStimulus();
    en = 1'b1;
    found = 0;
    for (int i = 0; i < 200 && !found; i++) begin
      if (mActive && goNow() && mT == 8 * mP - 1 && mQ.size() == 0) begin
        found = 1;
        clrUnderrun = 1'b1;
      end
      applyStimulus();
      clrUnderrun = 1'b0;
    end
    checkOutput("urun_event_found", found, 1);
    checkOutput("coincident_set_wins", underrun, 1);
    applyStimulus(); applyStimulus();
    clrUnderrun = 1'b1; applyStimulus(); clrUnderrun = 1'b0;
    checkOutput("isolated_clear", underrun, 0);

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      en          = ($urandom_range(0, 9) != 0);
      adpllMode   = ($urandom_range(0, 19) == 0) ? 2'($urandom_range(0, 2)) : 2'd3;
      channelLock = ($urandom_range(0, 14) != 0);
      if ($urandom_range(0, 49) == 0) symPeriod = 8'($urandom_range(0, 5));
      wrValid     = ($urandom_range(0, 3) == 0);
      wrData      = 8'($urandom);
      clrUnderrun = ($urandom_range(0, 29) == 0);
      applyStimulus();
      if ($urandom_range(0, 499) == 0) doReset();
    end

    $display("== %0d vectors applied, %0d miscompares ==", nChecks, nFails);
    $finish;
  end

endmodule
